// File: rtl/sd_cmd_responder.sv
`timescale 1ns/1ps
// Card-side SD CMD line responder: receives 48-bit host commands, checks framing and CRC7,
// and answers with an R1 response after a programmable NCR gap.
module sd_cmd_responder #(
    parameter int NCR          = 2,
    parameter bit NO_RESP_CMD0 = 1'b1
) (
    input  logic        clk_clk,
    input  logic        reset_reset_n,
    input  logic        sd_clk,
    input  logic        sd_cmd_in,
    output logic        sd_cmd_out,
    output logic        sd_cmd_oe,
    input  logic [31:0] card_status,
    output logic        cmd_valid,
    output logic [5:0]  cmd_index,
    output logic [31:0] cmd_arg,
    output logic        crc_err,
    output logic        busy,
    output logic [2:0]  dbg_state_o
);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_RX    = 3'd1;
    localparam logic [2:0] S_CHECK = 3'd2;
    localparam logic [2:0] S_WAIT  = 3'd3;
    localparam logic [2:0] S_TX    = 3'd4;

    function automatic logic [6:0] crc7_next(input logic [6:0] c, input logic b);
        logic fb;
        fb = c[6] ^ b;
        return {c[5:3], c[2] ^ fb, c[1:0], fb};
    endfunction

    logic        clk_s1_q, clk_s2_q, clk_d1_q;
    logic        cmd_s1_q, cmd_s2_q;
    logic        rise, fall;
    logic [2:0]  state_q, state_d;
    logic [6:0]  bit_cnt_q, bit_cnt_d;
    logic [46:0] rx_sr_q, rx_sr_d;
    logic [6:0]  rx_crc_q, rx_crc_d;
    logic [39:0] tx_sr_q, tx_sr_d;
    logic [6:0]  tx_crc_q, tx_crc_d;
    logic [5:0]  tx_cnt_q, tx_cnt_d;
    logic        out_q, out_d, oe_q, oe_d;
    logic        valid_q, valid_d, err_q, err_d;
    logic [5:0]  idx_q, idx_d;
    logic [31:0] arg_q, arg_d;
    logic        tx_bit;
    logic [39:0] tx_sr_nxt;
    logic [6:0]  tx_crc_nxt;

    assign rise = clk_s2_q & ~clk_d1_q;
    assign fall = ~clk_s2_q & clk_d1_q;

    // Response bit for slot tx_cnt_q: 40 payload bits feed the CRC, then 7 CRC bits, then the end bit.
    always_comb begin
        tx_bit     = 1'b1;
        tx_sr_nxt  = tx_sr_q;
        tx_crc_nxt = tx_crc_q;
        if (tx_cnt_q < 6'd40) begin
            tx_bit     = tx_sr_q[39];
            tx_sr_nxt  = {tx_sr_q[38:0], 1'b0};
            tx_crc_nxt = crc7_next(tx_crc_q, tx_sr_q[39]);
        end else if (tx_cnt_q < 6'd47) begin
            tx_bit     = tx_crc_q[6];
            tx_crc_nxt = {tx_crc_q[5:0], 1'b0};
        end
    end

    always_comb begin
        state_d   = state_q;
        bit_cnt_d = bit_cnt_q;
        rx_sr_d   = rx_sr_q;
        rx_crc_d  = rx_crc_q;
        tx_sr_d   = tx_sr_q;
        tx_crc_d  = tx_crc_q;
        tx_cnt_d  = tx_cnt_q;
        out_d     = out_q;
        oe_d      = oe_q;
        valid_d   = 1'b0;
        err_d     = 1'b0;
        idx_d     = idx_q;
        arg_d     = arg_q;
        case (state_q)
            S_IDLE: begin
                if (rise && !cmd_s2_q) begin
                    state_d   = S_RX;
                    bit_cnt_d = 7'd46;
                    rx_sr_d   = {46'd0, cmd_s2_q};
                    rx_crc_d  = 7'd0;
                end
            end
            S_RX: begin
                if (rise) begin
                    rx_sr_d = {rx_sr_q[45:0], cmd_s2_q};
                    if (bit_cnt_q >= 7'd8) rx_crc_d = crc7_next(rx_crc_q, cmd_s2_q);
                    if (bit_cnt_q == 7'd0) state_d = S_CHECK;
                    else bit_cnt_d = bit_cnt_q - 7'd1;
                end
            end
            S_CHECK: begin
                state_d = S_IDLE;
                // Frames with a card transmission bit or a missing end bit are dropped silently.
                if (rx_sr_q[46] && rx_sr_q[0]) begin
                    if (rx_crc_q != rx_sr_q[7:1]) begin
                        err_d = 1'b1;
                    end else begin
                        valid_d   = 1'b1;
                        idx_d     = rx_sr_q[45:40];
                        arg_d     = rx_sr_q[39:8];
                        tx_sr_d   = {2'b00, rx_sr_q[45:40], card_status};
                        tx_crc_d  = 7'd0;
                        tx_cnt_d  = 6'd0;
                        bit_cnt_d = 7'(NCR);
                        if (!(NO_RESP_CMD0 && rx_sr_q[45:40] == 6'd0)) state_d = S_WAIT;
                    end
                end
            end
            S_WAIT: begin
                if (rise && bit_cnt_q != 7'd0) bit_cnt_d = bit_cnt_q - 7'd1;
                if (fall && bit_cnt_q == 7'd0) begin
                    state_d  = S_TX;
                    out_d    = tx_bit;
                    oe_d     = 1'b1;
                    tx_sr_d  = tx_sr_nxt;
                    tx_crc_d = tx_crc_nxt;
                    tx_cnt_d = tx_cnt_q + 6'd1;
                end
            end
            S_TX: begin
                if (fall) begin
                    if (tx_cnt_q == 6'd48) begin
                        state_d = S_IDLE;
                        oe_d    = 1'b0;
                        out_d   = 1'b1;
                    end else begin
                        out_d    = tx_bit;
                        oe_d     = 1'b1;
                        tx_sr_d  = tx_sr_nxt;
                        tx_crc_d = tx_crc_nxt;
                        tx_cnt_d = tx_cnt_q + 6'd1;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_clk) begin
        if (!reset_reset_n) begin
            clk_s1_q  <= 1'b0;
            clk_s2_q  <= 1'b0;
            clk_d1_q  <= 1'b0;
            cmd_s1_q  <= 1'b1;
            cmd_s2_q  <= 1'b1;
            state_q   <= S_IDLE;
            bit_cnt_q <= 7'd0;
            rx_sr_q   <= '0;
            rx_crc_q  <= 7'd0;
            tx_sr_q   <= '0;
            tx_crc_q  <= 7'd0;
            tx_cnt_q  <= 6'd0;
            out_q     <= 1'b1;
            oe_q      <= 1'b0;
            valid_q   <= 1'b0;
            err_q     <= 1'b0;
            idx_q     <= 6'd0;
            arg_q     <= 32'd0;
        end else begin
            clk_s1_q  <= sd_clk;
            clk_s2_q  <= clk_s1_q;
            clk_d1_q  <= clk_s2_q;
            cmd_s1_q  <= sd_cmd_in;
            cmd_s2_q  <= cmd_s1_q;
            state_q   <= state_d;
            bit_cnt_q <= bit_cnt_d;
            rx_sr_q   <= rx_sr_d;
            rx_crc_q  <= rx_crc_d;
            tx_sr_q   <= tx_sr_d;
            tx_crc_q  <= tx_crc_d;
            tx_cnt_q  <= tx_cnt_d;
            out_q     <= out_d;
            oe_q      <= oe_d;
            valid_q   <= valid_d;
            err_q     <= err_d;
            idx_q     <= idx_d;
            arg_q     <= arg_d;
        end
    end

    assign sd_cmd_out  = out_q;
    assign sd_cmd_oe   = oe_q;
    assign cmd_valid   = valid_q;
    assign crc_err     = err_q;
    assign cmd_index   = idx_q;
    assign cmd_arg     = arg_q;
    assign busy        = (state_q != S_IDLE);
    assign dbg_state_o = state_q;

endmodule

// File: tb/tb_sd_cmd_responder.sv
`timescale 1ns/1ps
// Bench for sd_cmd_responder: a host model sends directed command frames while two
// monitors compare DUT pulses and response frames against expected queues.
module tb_sd_cmd_responder;

    localparam int NCR = 2;

    logic        clk_clk = 1'b0;
    logic        reset_reset_n = 1'b0;
    logic        sd_clk = 1'b0;
    logic        sd_cmd_in = 1'b1;
    logic        sd_cmd_out, sd_cmd_oe;
    logic [31:0] card_status = 32'd0;
    logic        cmd_valid, crc_err, busy;
    logic [5:0]  cmd_index;
    logic [31:0] cmd_arg;
    logic [2:0]  dbg_state_o;

    int checks = 0;
    int errors = 0;

    // Pulse expectations: {type, index, arg}; type 1 = cmd_valid, 2 = crc_err.
    logic [39:0] exp_q[$];
    logic [47:0] rsp_exp_q[$];
    logic [39:0] pulse_got;
    logic [47:0] rsp_sr = '0;
    int          rbits = 0;
    int          oe_bits = 0;
    int          rise_cnt = 0;
    int          end_rise = 0;
    bit          abort_mode = 1'b0;

    sd_cmd_responder #(.NCR(NCR), .NO_RESP_CMD0(1'b1)) dut (
        .clk_clk       (clk_clk),
        .reset_reset_n (reset_reset_n),
        .sd_clk        (sd_clk),
        .sd_cmd_in     (sd_cmd_in),
        .sd_cmd_out    (sd_cmd_out),
        .sd_cmd_oe     (sd_cmd_oe),
        .card_status   (card_status),
        .cmd_valid     (cmd_valid),
        .cmd_index     (cmd_index),
        .cmd_arg       (cmd_arg),
        .crc_err       (crc_err),
        .busy          (busy),
        .dbg_state_o   (dbg_state_o)
    );

    // ---------------- clock / reset ----------------
    always #5 clk_clk = ~clk_clk;
    initial begin
        #2;
        forever #40 sd_clk = ~sd_clk;
    end

    initial begin
        #2ms;
        $display("FAIL watchdog act=timeout exp=finish checks=%0d errors=%0d", checks, errors);
        $fatal(1, "watchdog expired");
    end

    // ---------------- helpers ----------------
    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s act=%h exp=%h", name, act, exp);
        end
    endtask

    function automatic logic [6:0] crc7(input logic [39:0] d);
        logic [6:0] c;
        logic       fb;
        c = 7'd0;
        for (int i = 39; i >= 0; i--) begin
            fb = c[6] ^ d[i];
            c  = {c[5:0], 1'b0};
            if (fb) c = c ^ 7'h09;
        end
        return c;
    endfunction

    function automatic logic [47:0] r1(input logic [5:0] idx, input logic [31:0] st);
        logic [39:0] body;
        body = {2'b00, idx, st};
        return {body, crc7(body), 1'b1};
    endfunction

    // ---------------- driver tasks ----------------
    task automatic send_frame(input logic [47:0] f);
        for (int i = 47; i >= 0; i--) begin
            @(negedge sd_clk);
            #1 sd_cmd_in = f[i];
        end
        @(posedge sd_clk);
        #1 end_rise = rise_cnt;
        @(negedge sd_clk);
        #1 sd_cmd_in = 1'b1;
    endtask

    task automatic idle_clks(input int n);
        repeat (n) @(posedge sd_clk);
    endtask

    // ---------------- monitors ----------------
    always @(negedge clk_clk) begin
        if (reset_reset_n === 1'b1 && (cmd_valid === 1'b1 || crc_err === 1'b1)) begin
            pulse_got = cmd_valid ? {2'd1, cmd_index, cmd_arg} : {2'd2, 38'd0};
            if (cmd_valid && crc_err) pulse_got = {2'd3, 38'd0};
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_pulse act=%h exp=none", pulse_got);
            end else begin
                check("pulse", pulse_got, exp_q.pop_front());
            end
        end
    end

    always @(posedge sd_clk) begin
        if (sd_cmd_oe === 1'b1) begin
            if (rbits == 0 && !abort_mode) check("ncr_gap", rise_cnt - end_rise, NCR);
            rsp_sr = {rsp_sr[46:0], sd_cmd_out};
            rbits++;
            oe_bits++;
        end else if (rbits != 0) begin
            if (!abort_mode) begin
                if (rsp_exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_response act=%h exp=none", rsp_sr);
                end else begin
                    check("rsp_len", rbits, 48);
                    check("rsp_frame", rsp_sr, rsp_exp_q.pop_front());
                end
            end
            rbits = 0;
        end
        rise_cnt++;
    end

    // ---------------- stimulus ----------------
    initial begin
        int  oe_before;
        bit  found;

        repeat (4) @(posedge clk_clk);
        #1;
        check("rst_out", sd_cmd_out, 1);
        check("rst_oe", sd_cmd_oe, 0);
        check("rst_valid", cmd_valid, 0);
        check("rst_crc_err", crc_err, 0);
        check("rst_index", cmd_index, 0);
        check("rst_arg", cmd_arg, 0);
        check("rst_busy", busy, 0);
        check("rst_state", dbg_state_o, 0);
        reset_reset_n = 1'b1;
        idle_clks(4);

        // CMD0: accepted, but no response
        exp_q.push_back({2'd1, 6'd0, 32'd0});
        oe_before = oe_bits;
        send_frame(48'h40_0000_0000_95);
        idle_clks(100);
        check("cmd0_no_oe", oe_bits, oe_before);
        check("cmd0_busy", busy, 0);

        // CMD17 with status 0x900
        card_status = 32'h0000_0900;
        exp_q.push_back({2'd1, 6'd17, 32'd0});
        rsp_exp_q.push_back(r1(6'd17, 32'h0000_0900));
        send_frame(48'h51_0000_0000_55);
        idle_clks(60);
        check("cmd17_index", cmd_index, 17);

        // CMD8 with argument 0x1AA
        card_status = 32'h0000_0120;
        exp_q.push_back({2'd1, 6'd8, 32'h0000_01AA});
        rsp_exp_q.push_back(r1(6'd8, 32'h0000_0120));
        send_frame(48'h48_0000_01AA_87);
        idle_clks(60);
        check("cmd8_arg", cmd_arg, 32'h0000_01AA);

        // CMD17 with a corrupted CRC field
        exp_q.push_back({2'd2, 38'd0});
        oe_before = oe_bits;
        send_frame(48'h51_0000_0000_A9);
        idle_clks(60);
        check("badcrc_no_oe", oe_bits, oe_before);
        check("badcrc_index_hold", cmd_index, 8);
        check("badcrc_arg_hold", cmd_arg, 32'h0000_01AA);

        // Transmission bit 0: dropped silently, then a normal CMD17
        oe_before = oe_bits;
        send_frame(48'h11_0000_0000_55);
        idle_clks(10);
        check("trans0_no_oe", oe_bits, oe_before);
        check("trans0_busy", busy, 0);
        card_status = 32'h0000_0B00;
        exp_q.push_back({2'd1, 6'd17, 32'd0});
        rsp_exp_q.push_back(r1(6'd17, 32'h0000_0B00));
        send_frame(48'h51_0000_0000_55);
        idle_clks(60);

        // Reset while response bit 20 is on the line
        abort_mode  = 1'b1;
        card_status = 32'h0000_0900;
        exp_q.push_back({2'd1, 6'd17, 32'd0});
        send_frame(48'h51_0000_0000_55);
        found = 1'b0;
        for (int i = 0; i < 200; i++) begin
            @(posedge sd_clk);
            #1;
            if (rbits >= 20) begin
                found = 1'b1;
                break;
            end
        end
        check("reach_tx_bit20", found, 1);
        @(negedge sd_clk);
        #35;
        @(posedge clk_clk);
        #1 reset_reset_n = 1'b0;
        @(posedge clk_clk);
        #1;
        check("abort_oe", sd_cmd_oe, 0);
        check("abort_out", sd_cmd_out, 1);
        check("abort_busy", busy, 0);
        reset_reset_n = 1'b1;
        idle_clks(10);
        check("abort_quiet_oe", sd_cmd_oe, 0);
        abort_mode = 1'b0;

        // CMD0 after the reset
        exp_q.push_back({2'd1, 6'd0, 32'd0});
        oe_before = oe_bits;
        send_frame(48'h40_0000_0000_95);
        idle_clks(60);
        check("post_reset_cmd0_no_oe", oe_bits, oe_before);
        check("post_reset_cmd0_index", cmd_index, 0);

        // ---------------- final report ----------------
        check("exp_q_drained", exp_q.size(), 0);
        check("rsp_q_drained", rsp_exp_q.size(), 0);
        check("line_released", rbits, 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/sd_cmd_responder.md
Name: sd_cmd_responder

Overview:
- Card-side responder for the SD CMD line, i.e. the far end of the host-side SD pins (sd_clk, sd_cmd, sd_dat) of the system.
- Receives 48-bit host command frames, checks framing and CRC7, and presents index and argument to local logic.
- Returns a 48-bit R1-format response after a programmable NCR gap.
- Used as an in-FPGA card emulator for host bring-up and loopback test.

Parameters:
- NCR, 2, number of sd_clk rising edges between the host end bit and the falling edge that launches the response start bit; legal range 2..64.
- NO_RESP_CMD0, 1, when 1, CMD0 produces no response.

Ports:
- clk_clk  input  1  system clock; must be at least 4x the sd_clk frequency.
- reset_reset_n  input  1  synchronous reset, active-low.
- sd_clk  input  1  host SD clock; asynchronous to clk_clk.
- sd_cmd_in  input  1  CMD line as seen from the pad.
- sd_cmd_out  output  1  CMD value to drive.
- sd_cmd_oe  output  1  tristate enable; 1 means drive.
- card_status  input  32  R1 payload; sampled in CHECK.
- cmd_valid  output  1  one-clk_clk pulse when a valid command has been received.
- cmd_index  output  6  index of the last valid command.
- cmd_arg  output  32  argument of the last valid command.
- crc_err  output  1  one-clk_clk pulse on CRC7 mismatch.
- busy  output  1  high in every state except IDLE.

Behaviour:
- Reset values: sd_cmd_out=1, sd_cmd_oe=0, cmd_valid=0, crc_err=0, cmd_index=0, cmd_arg=0, busy=0, state=IDLE.
- Synchronisation: sd_clk and sd_cmd_in each pass through 2 flops. rise = sync_clk 0->1; fall = sync_clk 1->0.
- Sampling and driving: CMD is sampled only on rise. sd_cmd_out and sd_cmd_oe change only on fall (or on reset).
- CRC7: polynomial x^7+x^3+1, initial value 0. Covers bits 47..8 of a frame (start, transmission, index, argument). Computed serially in both directions.
- Frame layout, MSB first: start(0), transmission(1 for host, 0 for card), index[5:0], arg[31:0], crc[6:0], end(1).

State machine:
- IDLE: a rise with sampled CMD=0 -> RX, bit counter=46, shift register loaded with the start bit.
- RX: shift one bit per rise; when the counter reaches 0 -> CHECK.
- CHECK (exactly one clk_clk cycle):
  - Transmission bit=0 or end bit=0: drop silently -> IDLE.
  - CRC mismatch: crc_err=1 -> IDLE.
  - Otherwise: cmd_valid=1; cmd_index and cmd_arg updated; card_status latched. Then -> IDLE if the index is 0 and NO_RESP_CMD0=1, else -> WAIT_NCR with counter=NCR.
- WAIT_NCR: decrement on each rise; at 0, the next fall -> TX.
- TX:
  - On each fall, drive the next response bit with oe=1.
  - Response: 0, 0, index, latched status, CRC7, 1.
  - On the fall after the end bit has been driven for one sd_clk period: oe=0, out=1 -> IDLE.
- The response launches on the first fall after the NCR-th rise following the end bit. Response bits change only on falls.
- cmd_index and cmd_arg hold their values until the next valid command.
- CMD activity during WAIT_NCR and TX is ignored; the responder never receives while driving.
- sd_clk stopped mid-frame: state holds indefinitely; there is no timeout.
- Reset asserted in any state: next clk_clk edge gives IDLE, oe=0, out=1, pulses cleared, counters zeroed.
- Simultaneous rise and reset: reset wins.
- Start bit of a new frame in the rise immediately after returning to IDLE: accepted.

Test Plan:
- CMD0, arg 0, frame 40 00 00 00 00 95 -> cmd_valid pulse, cmd_index=0, cmd_arg=0; sd_cmd_oe stays 0 for 100 sd_clk.
- CMD17, arg 0 (51 00 00 00 00 55), card_status=0x00000900, NCR=2 -> cmd_valid, cmd_index=17. The response start bit launches on the first fall after the 2nd rise past the end bit. Response bits are 0,0,010001,0x00000900, CRC7 equal to the bench model, 1. oe drops one period after the end bit.
- CMD8, arg 0x000001AA, CRC 0x43 (48 00 00 01 AA 87) -> cmd_arg=0x000001AA; response index field=001000.
- CMD17 with CRC byte 0x54 -> crc_err pulse; no cmd_valid; oe stays 0; cmd_index and cmd_arg keep their previous values.
- Frame with transmission bit=0 -> no cmd_valid, no crc_err, returns to IDLE. The next valid CMD17 is received normally.
- reset_reset_n=0 for one clk_clk during TX bit 20 -> sd_cmd_oe=0 and sd_cmd_out=1 on the next clk_clk edge, busy=0. The following CMD0 is received correctly.
